mmio_uart_tx: RTL and testbench

MMIO_UART_TX -- requirements
Module: mmio_uart_tx

---
 rtl/mmio_uart_tx_pkg.sv | 29 ++
 rtl/mmio_uart_tx_fifo.sv | 61 ++++++
 rtl/mmio_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the MMIO UART transmitter: register map,
// STATUS/CTRL bit positions and serializer state encodings.
package mmio_uart_tx_pkg;

  localparam int RAM_ADDR_WIDTH = 32;

  // Register offsets (word index within the 16-byte window)
  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;

  // STATUS bit positions
  localparam int ST_BUSY_BIT  = 0;
  localparam int ST_FULL_BIT  = 1;
  localparam int ST_EMPTY_BIT = 2;
  localparam int ST_OVF_BIT   = 3;
  localparam int ST_CNT_LSB   = 4;

  // CTRL bit positions
  localparam int CTRL_TXEN_BIT = 0;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_fifo.sv
// sync_fifo: single-clock FIFO. The count register is the only source of
// full/empty; pointers wrap modulo DEPTH. A push into a full FIFO is taken
// only when a pop happens in the same cycle. Head data is read directly
// from storage, so a pushed byte is poppable from the next cycle on.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       gated_clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [0:(1<<PW)-1];
  logic [PW-1:0]    r_wptr, r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push, w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping
  always_ff @(posedge gated_clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge gated_clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a TX FIFO.
// Build option: define UART_TX_FIFO_EN for an 8-entry FIFO; otherwise a
// single holding register (depth 1) is used.
// Register window (BASE_ADDR, 16 bytes): +0 TXDATA (W), +4 STATUS (R/W1C),
// +8 CTRL (R/W), +12 reads 0.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_F000,
  parameter int          CLKS_PER_BIT = 1085
) (
  input  logic                      gated_clk,
  input  logic                      rst,
  input  logic [RAM_ADDR_WIDTH-1:0] d_w_addr,
  input  logic [31:0]               d_w_dat,
  input  logic                      d_w_enb,
  input  logic [3:0]                d_w_byte_enb,
  input  logic [RAM_ADDR_WIDTH-1:0] d_r_addr,
  input  logic                      d_r_enb,
  output logic [31:0]               mmio_r_dat,
  output logic                      mmio_hit,
  output logic                      uart_tx,
  output logic                      tx_busy
);

`ifdef UART_TX_FIFO_EN
  localparam int FIFO_DEPTH = 8;
`else
  localparam int FIFO_DEPTH = 1;
`endif
  localparam int FCW   = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_shift;
  logic [2:0]       r_bit;
  logic             r_ovf, r_tx_en;

  logic             w_w_hit, w_push, w_pop, w_drop, w_ovf_clr, w_ctrl_wr;
  logic [1:0]       w_w_ofs, w_r_ofs;
  logic [7:0]       w_head;
  logic [FCW-1:0]   w_count;
  logic             w_full, w_empty;
  logic [31:0]      w_status;
  logic             w_unused;

  // Write-side decode
  assign w_w_hit   = d_w_enb &&
                     (d_w_addr[RAM_ADDR_WIDTH-1:4] == BASE_ADDR[RAM_ADDR_WIDTH-1:4]);
  assign w_w_ofs   = d_w_addr[3:2];
  assign w_push    = w_w_hit && (w_w_ofs == OFS_TXDATA) && d_w_byte_enb[0];
  assign w_ovf_clr = w_w_hit && (w_w_ofs == OFS_STATUS) && d_w_byte_enb[0] &&
                     d_w_dat[ST_OVF_BIT];
  assign w_ctrl_wr = w_w_hit && (w_w_ofs == OFS_CTRL) && d_w_byte_enb[0];
  assign w_drop    = w_push && w_full && !w_pop;

  assign w_unused  = ^{d_w_dat[31:8], d_w_byte_enb[3:1], d_w_addr[1:0], d_r_addr[1:0]};

  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .gated_clk (gated_clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wdata   (d_w_dat[7:0]),
    .i_pop     (w_pop),
    .o_rdata   (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  assign tx_busy = (r_state != TX_IDLE) || !w_empty;

  // Sticky overflow (set wins over clear) and CTRL register
  always_ff @(posedge gated_clk or posedge rst) begin
    if (rst) begin
      r_ovf   <= 1'b0;
      r_tx_en <= 1'b1;
    end else begin
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      if (w_ctrl_wr)      r_tx_en <= d_w_dat[CTRL_TXEN_BIT];
    end
  end

  // STATUS image
  always_comb begin
    w_status = '0;
    w_status[ST_BUSY_BIT]            = tx_busy;
    w_status[ST_FULL_BIT]            = w_full;
    w_status[ST_EMPTY_BIT]           = w_empty;
    w_status[ST_OVF_BIT]             = r_ovf;
    w_status[ST_CNT_LSB+3:ST_CNT_LSB] = 4'(w_count);
  end

  // Zero-latency read mux; returns 0 unless the window is addressed
  assign w_r_ofs  = d_r_addr[3:2];
  assign mmio_hit = d_r_enb &&
                    (d_r_addr[RAM_ADDR_WIDTH-1:4] == BASE_ADDR[RAM_ADDR_WIDTH-1:4]);
  always_comb begin
    mmio_r_dat = '0;
    if (mmio_hit) begin
      case (w_r_ofs)
        OFS_STATUS: mmio_r_dat = w_status;
        OFS_CTRL:   mmio_r_dat = {31'b0, r_tx_en};
        default:    mmio_r_dat = '0;
      endcase
    end
  end

  // Serializer state register; reset drops any frame immediately
  always_ff @(posedge gated_clk or posedge rst) begin
    if (rst) r_state <= TX_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Serializer next state, FIFO pop and line level
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    uart_tx     = 1'b1;
    case (r_state)
      TX_IDLE: begin
        if (!w_empty && r_tx_en) begin
          w_state_nxt = TX_START;
          w_pop       = 1'b1;
        end
      end
      TX_START: begin
        uart_tx = 1'b0;
        if (r_cnt == '0) w_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        uart_tx = r_shift[0];
        if (r_cnt == '0 && r_bit == 3'd7) w_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        if (r_cnt == '0) w_state_nxt = TX_IDLE;
      end
      default: w_state_nxt = TX_IDLE;
    endcase
  end

  // Bit timer, shift register and data-bit index
  always_ff @(posedge gated_clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
      r_bit   <= '0;
    end else if (r_state == TX_IDLE) begin
      if (w_pop) begin
        r_shift <= w_head;
        r_cnt   <= CNT_LOAD;
        r_bit   <= '0;
      end
    end else if (r_cnt == '0) begin
      r_cnt <= CNT_LOAD;
      if (r_state == TX_DATA) begin
        r_shift <= r_shift >> 1;
        r_bit   <= r_bit + 1'b1;
      end
    end else begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx at CLKS_PER_BIT=4. Expectations follow
// the build option UART_TX_FIFO_EN (FIFO depth 8 when defined, else 1).
module tb_mmio_uart_tx;
  import mmio_uart_tx_pkg::*;

  localparam int          CPB  = 4;
  localparam logic [31:0] BASE = 32'h0000_F000;
`ifdef UART_TX_FIFO_EN
  localparam int          DEPTH    = 8;
  localparam int          BURST_N  = 3;
  localparam logic [31:0] BURST_ST = 32'h21;
`else
  localparam int          DEPTH    = 1;
  localparam int          BURST_N  = 2;
  localparam logic [31:0] BURST_ST = 32'h1B;
`endif
  localparam logic [31:0] OVF_ST = 32'h0B | (DEPTH << 4);
  localparam logic [31:0] FUL_ST = 32'h03 | (DEPTH << 4);

  logic        gated_clk, rst;
  logic [31:0] d_w_addr, d_w_dat, d_r_addr, mmio_r_dat;
  logic        d_w_enb, d_r_enb, mmio_hit, uart_tx, tx_busy;
  logic [3:0]  d_w_byte_enb;

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB)) dut (
    .gated_clk    (gated_clk),
    .rst          (rst),
    .d_w_addr     (d_w_addr),
    .d_w_dat      (d_w_dat),
    .d_w_enb      (d_w_enb),
    .d_w_byte_enb (d_w_byte_enb),
    .d_r_addr     (d_r_addr),
    .d_r_enb      (d_r_enb),
    .mmio_r_dat   (mmio_r_dat),
    .mmio_hit     (mmio_hit),
    .uart_tx      (uart_tx),
    .tx_busy      (tx_busy)
  );

  initial begin
    gated_clk = 1'b0;
    forever #5 gated_clk = ~gated_clk;
  end

  int cyc = 0;
  always @(posedge gated_clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One write, captured at the next posedge; call at a negedge
  task automatic wr(input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] be);
    d_w_addr     = addr;
    d_w_dat      = dat;
    d_w_byte_enb = be;
    d_w_enb      = 1'b1;
    @(negedge gated_clk);
    d_w_enb      = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] dat, output logic hit);
    d_r_addr = addr;
    d_r_enb  = 1'b1;
    #1;
    dat      = mmio_r_dat;
    hit      = mmio_hit;
    d_r_enb  = 1'b0;
  endtask

  // Line monitor: decodes frames mid-bit, records byte, start cycle, stop level
  logic [7:0] q_byte[$];
  int         q_t[$];
  logic       q_stop[$];
  initial begin
    bit         inframe;
    int         ph, t0;
    logic [7:0] sh;
    inframe = 0; ph = 0; t0 = 0; sh = '0;
    forever begin
      @(negedge gated_clk);
      if (rst) inframe = 0;
      else if (!inframe) begin
        if (uart_tx == 1'b0) begin inframe = 1; ph = 0; t0 = cyc; end
      end else begin
        ph++;
        if (ph >= 4 && ph < 36 && (ph % 4) == 2) sh = {uart_tx, sh[7:1]};
        if (ph == 38) begin
          q_byte.push_back(sh);
          q_t.push_back(t0);
          q_stop.push_back(uart_tx);
          inframe = 0;
        end
      end
    end
  end

  task automatic clr_q();
    q_byte.delete(); q_t.delete(); q_stop.delete();
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k = 0;
    while (q_byte.size() < n && k < budget) begin
      @(negedge gated_clk);
      k++;
    end
    chk("frame_count", q_byte.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rdat;
    logic        hit;
    logic [9:0]  frm;
    int          tw;

    rst = 1'b1; d_w_enb = 1'b0; d_r_enb = 1'b0; d_w_addr = '0; d_r_addr = '0;
    d_w_dat = '0; d_w_byte_enb = '0;
    repeat (3) @(negedge gated_clk);
    chk("rst_uart_tx", uart_tx, 1);
    chk("rst_tx_busy", tx_busy, 0);
    rst = 1'b0;
    @(negedge gated_clk);
    rd(BASE + 4, rdat, hit);
    chk("rst_status", rdat, 32'h04);
    chk("rst_status_hit", hit, 1);
    rd(BASE + 8, rdat, hit);
    chk("rst_ctrl", rdat, 32'h01);

    // TXDATA write without byte lane 0 is ignored
    wr(BASE, 32'h55, 4'hE);
    rd(BASE + 4, rdat, hit);
    chk("lane0_off_status", rdat, 32'h04);

    // Single byte 0xA5, checked every cycle
    clr_q();
    wr(BASE, 32'h0000_00A5, 4'h1);
    tw = cyc;
    chk("a5_pre_uart", uart_tx, 1);
    chk("a5_pre_busy", tx_busy, 1);
    frm = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      @(negedge gated_clk);
      chk($sformatf("a5_cyc%0d", i), uart_tx, frm[i/CPB]);
    end
    @(negedge gated_clk);
    chk("a5_busy_after", tx_busy, 0);
    chk("a5_idle_line", uart_tx, 1);
    chk("a5_start_latency", q_t.size() > 0 ? q_t[0] - tw : -1, 1);
    rd(BASE + 4, rdat, hit);
    chk("a5_status_end", rdat, 32'h04);

    // Burst of three back-to-back writes
    clr_q();
    wr(BASE, 32'h01, 4'h1);
    wr(BASE, 32'h02, 4'h1);
    wr(BASE, 32'h03, 4'h1);
    rd(BASE + 4, rdat, hit);
    chk("burst_status", rdat, BURST_ST);
    wait_frames(BURST_N, 300);
    for (int i = 0; i < q_byte.size(); i++) begin
      chk($sformatf("burst_byte%0d", i), q_byte[i], 8'(i + 1));
      chk($sformatf("burst_stop%0d", i), q_stop[i], 1);
      if (i > 0) chk($sformatf("burst_gap%0d", i), q_t[i] - q_t[i-1], 10*CPB + 1);
    end
    repeat (4) @(negedge gated_clk);
    wr(BASE + 4, 32'h8, 4'h1);
    rd(BASE + 4, rdat, hit);
    chk("burst_status_end", rdat, 32'h04);

    // Overflow with transmitter disabled, then W1C
    clr_q();
    wr(BASE + 8, 32'h0, 4'h1);
    for (int i = 0; i < 10; i++) wr(BASE, 32'h10 + i, 4'h1);
    rd(BASE + 4, rdat, hit);
    chk("ovf_status", rdat, OVF_ST);
    wr(BASE + 4, 32'h8, 4'h1);
    rd(BASE + 4, rdat, hit);
    chk("ovf_cleared", rdat, FUL_ST);
    chk("ovf_no_frames", q_byte.size(), 0);
    chk("ovf_line_idle", uart_tx, 1);

    // Enable, then push on the pop cycle while full
    clr_q();
    wr(BASE + 8, 32'h1, 4'h1);
    wr(BASE, 32'h77, 4'h1);
    rd(BASE + 4, rdat, hit);
    chk("fullpop_status", rdat, FUL_ST);
    rd(BASE + 8, rdat, hit);
    chk("fullpop_ctrl", rdat, 32'h1);
    wait_frames(DEPTH + 1, 600);
    for (int i = 0; i < q_byte.size(); i++)
      chk($sformatf("drain_byte%0d", i), q_byte[i], (i < DEPTH) ? 8'(8'h10 + i) : 8'h77);
    repeat (4) @(negedge gated_clk);
    rd(BASE + 4, rdat, hit);
    chk("drain_status", rdat, 32'h04);

    // Reset during DATA bit 3 of 0xA5
    clr_q();
    wr(BASE, 32'hA5, 4'h1);
    repeat (18) @(negedge gated_clk);
    chk("midrst_bit3_low", uart_tx, 0);
    #1 rst = 1'b1;
    #1;
    chk("midrst_uart_async", uart_tx, 1);
    chk("midrst_busy", tx_busy, 0);
    repeat (2) @(negedge gated_clk);
    rst = 1'b0;
    @(negedge gated_clk);
    rd(BASE + 4, rdat, hit);
    chk("midrst_status", rdat, 32'h04);
    chk("midrst_line", uart_tx, 1);

    // Address decode edges
    rd(BASE + 12, rdat, hit);
    chk("dec_ofs3_dat", rdat, 0);
    chk("dec_ofs3_hit", hit, 1);
    rd(BASE + 16, rdat, hit);
    chk("dec_out_dat", rdat, 0);
    chk("dec_out_hit", hit, 0);
    d_r_addr = BASE + 4;
    d_r_enb  = 1'b0;
    #1;
    chk("dec_noen_hit", mmio_hit, 0);
    chk("dec_noen_dat", mmio_r_dat, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
